// File: rtl/mem_buffer_writer.sv
// mem_buffer_writer: consumer end of a per-stream buffer-descriptor interface.
// Pops (vaddr, size) descriptors, stamps a virtual address on each beat of the
// incoming stream, closes a buffer when it is full or the stream ends, and
// reports a completion record. A flush pulse closes the current buffer and
// discards every stale descriptor still queued upstream.
module mem_buffer_writer #(
  parameter int unsigned VADDR_BITS = 48,
  parameter int unsigned SIZE_BITS  = 28,
  parameter int unsigned DATA_BITS  = 512,
  parameter int unsigned BEAT_BYTES = DATA_BITS / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // descriptor interface
  input  logic                  buf_valid,
  output logic                  buf_ready,
  input  logic [VADDR_BITS-1:0] buf_vaddr,
  input  logic [SIZE_BITS-1:0]  buf_size,
  input  logic                  flush_buffers,
  // input stream
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  in_last,
  // addressed output stream
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic [VADDR_BITS-1:0] out_vaddr,
  output logic                  out_buf_last,
  // completion records
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [VADDR_BITS-1:0] done_vaddr,
  output logic [SIZE_BITS-1:0]  done_bytes,
  output logic                  done_stream_end
);

  // byte offset bits inside one beat; BEAT_BYTES is a power of two
  localparam int unsigned OFF_BITS = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;

  // held low for the first cycle after reset so no handshake overlaps reset release
  logic                  run;

  logic [VADDR_BITS-1:0] base;
  logic [VADDR_BITS-1:0] base_nxt;
  logic [SIZE_BITS-1:0]  beats_total;
  logic [SIZE_BITS-1:0]  beats_total_nxt;
  logic [SIZE_BITS-1:0]  beat_cnt;
  logic [SIZE_BITS-1:0]  beat_cnt_nxt;
  logic                  flush_pending;
  logic                  flush_pending_nxt;

  logic [VADDR_BITS-1:0] done_vaddr_nxt;
  logic [SIZE_BITS-1:0]  done_bytes_nxt;
  logic                  done_stream_end_nxt;

  logic [SIZE_BITS-1:0]  desc_beats_c;
  logic                  last_c;
  logic                  beat_hs_c;
  logic [SIZE_BITS-1:0]  cnt_after_c;

  // usable whole beats in the offered descriptor; remainder bytes are dropped
  assign desc_beats_c = SIZE_BITS'(buf_size >> OFF_BITS);

  // beat payload is a straight pass-through; address is base plus beat offset
  assign out_data  = in_data;
  assign out_vaddr = base + (VADDR_BITS'(beat_cnt) << OFF_BITS);

  // state and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      run             <= 1'b0;
      base            <= '0;
      beats_total     <= '0;
      beat_cnt        <= '0;
      flush_pending   <= 1'b0;
      done_vaddr      <= '0;
      done_bytes      <= '0;
      done_stream_end <= 1'b0;
    end else begin
      state           <= state_nxt;
      run             <= 1'b1;
      base            <= base_nxt;
      beats_total     <= beats_total_nxt;
      beat_cnt        <= beat_cnt_nxt;
      flush_pending   <= flush_pending_nxt;
      done_vaddr      <= done_vaddr_nxt;
      done_bytes      <= done_bytes_nxt;
      done_stream_end <= done_stream_end_nxt;
    end
  end

  // next-state, handshake and bookkeeping decisions
  always_comb begin
    state_nxt           = state;
    base_nxt            = base;
    beats_total_nxt     = beats_total;
    beat_cnt_nxt        = beat_cnt;
    flush_pending_nxt   = flush_pending | flush_buffers;
    done_vaddr_nxt      = done_vaddr;
    done_bytes_nxt      = done_bytes;
    done_stream_end_nxt = done_stream_end;
    buf_ready           = 1'b0;
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    out_buf_last        = 1'b0;
    done_valid          = 1'b0;
    last_c              = (beat_cnt == (beats_total - SIZE_BITS'(1))) | in_last;
    beat_hs_c           = 1'b0;
    cnt_after_c         = beat_cnt;

    case (state)
      IDLE: begin
        buf_ready = run & ~flush_pending;
        if (flush_pending) begin
          state_nxt = DRAIN;
        end else if (run && buf_valid) begin
          base_nxt        = buf_vaddr;
          beats_total_nxt = desc_beats_c;
          beat_cnt_nxt    = '0;
          // a descriptor too small for one beat is silently dropped
          if (desc_beats_c != '0) begin
            state_nxt = ACTIVE;
          end
        end
      end

      ACTIVE: begin
        // the beat path closes from the cycle after a flush has been seen
        if (!flush_pending) begin
          out_valid    = in_valid;
          in_ready     = out_ready;
          out_buf_last = last_c;
        end
        beat_hs_c    = in_valid & out_ready & ~flush_pending;
        cnt_after_c  = beat_cnt + SIZE_BITS'(beat_hs_c);
        beat_cnt_nxt = cnt_after_c;
        if (beat_hs_c && last_c) begin
          state_nxt           = DONE;
          done_vaddr_nxt      = base;
          done_bytes_nxt      = SIZE_BITS'(cnt_after_c << OFF_BITS);
          done_stream_end_nxt = in_last;
        end else if (flush_buffers || flush_pending) begin
          if (cnt_after_c != '0) begin
            state_nxt           = DONE;
            done_vaddr_nxt      = base;
            done_bytes_nxt      = SIZE_BITS'(cnt_after_c << OFF_BITS);
            done_stream_end_nxt = 1'b0;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end

      DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_nxt = (flush_pending || flush_buffers) ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        // swallow every stale descriptor until the upstream queue runs dry
        buf_ready = 1'b1;
        if (!buf_valid) begin
          state_nxt         = IDLE;
          flush_pending_nxt = flush_buffers;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_buffer_writer.sv
// tb_mem_buffer_writer: directed bench for mem_buffer_writer with BEAT_BYTES = 64.
module tb_mem_buffer_writer;

  logic          clk;
  logic          rst_n;
  logic          buf_valid;
  logic          buf_ready;
  logic [47:0]   buf_vaddr;
  logic [27:0]   buf_size;
  logic          flush_buffers;
  logic          in_valid;
  logic          in_ready;
  logic [511:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [511:0]  out_data;
  logic [47:0]   out_vaddr;
  logic          out_buf_last;
  logic          done_valid;
  logic          done_ready;
  logic [47:0]   done_vaddr;
  logic [27:0]   done_bytes;
  logic          done_stream_end;

  mem_buffer_writer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .buf_valid       (buf_valid),
    .buf_ready       (buf_ready),
    .buf_vaddr       (buf_vaddr),
    .buf_size        (buf_size),
    .flush_buffers   (flush_buffers),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_vaddr       (out_vaddr),
    .out_buf_last    (out_buf_last),
    .done_valid      (done_valid),
    .done_ready      (done_ready),
    .done_vaddr      (done_vaddr),
    .done_bytes      (done_bytes),
    .done_stream_end (done_stream_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [47:0] v; logic [27:0] s; } desc_t;
  typedef struct packed { logic [511:0] d; logic l; } beat_t;
  typedef struct packed { logic [47:0] va; logic bl; logic ov; logic [511:0] d; } obs_beat_t;
  typedef struct packed { logic [47:0] va; logic [27:0] b; logic e; } obs_done_t;

  desc_t     dq[$];
  beat_t     bq[$];
  obs_beat_t beats[$];
  obs_done_t dones[$];
  int        pops;
  int        overlap;
  int        total;
  int        passed;
  logic      ready_cfg;
  logic      toggle_ready;
  logic      done_ready_cfg;
  logic      flush_next;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_data(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] mk(input int k);
    logic [63:0] w;
    w = 64'(k) ^ 64'hA5A5_0000_0000_0000;
    return {8{w}};
  endfunction

  function automatic int cnt(input int kind);
    if (kind == 0) return beats.size();
    if (kind == 1) return dones.size();
    return pops;
  endfunction

  // one clock: drive inputs after the falling edge, then log what the next rising edge will take
  task automatic tick();
    @(negedge clk);
    buf_valid = (dq.size() != 0);
    if (buf_valid) begin
      buf_vaddr = dq[0].v;
      buf_size  = dq[0].s;
    end
    in_valid = (bq.size() != 0);
    if (in_valid) begin
      in_data = bq[0].d;
      in_last = bq[0].l;
    end else begin
      in_last = 1'b0;
    end
    flush_buffers = flush_next;
    flush_next    = 1'b0;
    out_ready     = toggle_ready ? ~out_ready : ready_cfg;
    done_ready    = done_ready_cfg;
    #1;
    if (done_valid && out_valid) overlap++;
    if (buf_valid && buf_ready) begin
      void'(dq.pop_front());
      pops++;
    end
    if (in_valid && in_ready) begin
      beats.push_back('{va: out_vaddr, bl: out_buf_last, ov: out_valid, d: out_data});
      void'(bq.pop_front());
    end
    if (done_valid && done_ready) begin
      dones.push_back('{va: done_vaddr, b: done_bytes, e: done_stream_end});
    end
  endtask

  task automatic wait_count(input string tag, input int kind, input int target);
    int n;
    n = 0;
    while (cnt(kind) < target && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(cnt(kind)), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nd;
    int np;
    pops = 0; overlap = 0; total = 0; passed = 0;
    ready_cfg = 1'b1; toggle_ready = 1'b0; done_ready_cfg = 1'b1; flush_next = 1'b0;
    buf_valid = 1'b0; buf_vaddr = '0; buf_size = '0; flush_buffers = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; done_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    buf_valid = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("rst_buf_ready", 64'(buf_ready), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    @(negedge clk);
    buf_valid = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;

    // one 256-byte buffer filled by four beats
    nb = beats.size(); nd = dones.size();
    dq.push_back('{v: 48'h1000, s: 28'd256});
    for (int i = 0; i < 4; i++) bq.push_back('{d: mk(i + 1), l: 1'b0});
    wait_count("t1_done_cnt", 1, nd + 1);
    check("t1_beat_cnt", 64'(beats.size()), 64'(nb + 4));
    for (int i = 0; i < 4; i++) begin
      check("t1_vaddr", 64'(beats[nb + i].va), 64'h1000 + 64'(i * 64));
      check("t1_buf_last", 64'(beats[nb + i].bl), 64'(i == 3));
      check("t1_out_valid", 64'(beats[nb + i].ov), 64'd1);
      check_data("t1_data", beats[nb + i].d, mk(i + 1));
    end
    check("t1_done_vaddr", 64'(dones[nd].va), 64'h1000);
    check("t1_done_bytes", 64'(dones[nd].b), 64'd256);
    check("t1_done_end", 64'(dones[nd].e), 64'd0);

    // two 128-byte buffers, stream ends on the third beat
    nb = beats.size(); nd = dones.size();
    dq.push_back('{v: 48'h1000, s: 28'd128});
    dq.push_back('{v: 48'h8000, s: 28'd128});
    for (int i = 0; i < 3; i++) bq.push_back('{d: mk(10 + i), l: 1'(i == 2)});
    wait_count("t2_done_cnt", 1, nd + 2);
    check("t2_vaddr0", 64'(beats[nb].va), 64'h1000);
    check("t2_vaddr1", 64'(beats[nb + 1].va), 64'h1040);
    check("t2_vaddr2", 64'(beats[nb + 2].va), 64'h8000);
    check("t2_last0", 64'(beats[nb].bl), 64'd0);
    check("t2_last1", 64'(beats[nb + 1].bl), 64'd1);
    check("t2_last2", 64'(beats[nb + 2].bl), 64'd1);
    check("t2_done0", {15'd0, dones[nd].va, 1'b0}, {15'd0, 48'h1000, 1'b0});
    check("t2_bytes0", 64'(dones[nd].b), 64'd128);
    check("t2_done1", {15'd0, dones[nd + 1].va, dones[nd + 1].e}, {15'd0, 48'h8000, 1'b1});
    check("t2_bytes1", 64'(dones[nd + 1].b), 64'd64);

    // remainder bytes ignored; a sub-beat descriptor is dropped
    nb = beats.size(); nd = dones.size(); np = pops;
    dq.push_back('{v: 48'h2000, s: 28'd100});
    dq.push_back('{v: 48'h3000, s: 28'd32});
    dq.push_back('{v: 48'h4000, s: 28'd64});
    bq.push_back('{d: mk(20), l: 1'b0});
    bq.push_back('{d: mk(21), l: 1'b1});
    wait_count("t3_done_cnt", 1, nd + 2);
    check("t3_pops", 64'(pops), 64'(np + 3));
    check("t3_vaddr0", 64'(beats[nb].va), 64'h2000);
    check("t3_vaddr1", 64'(beats[nb + 1].va), 64'h4000);
    check("t3_bytes0", 64'(dones[nd].b), 64'd64);
    check("t3_end0", 64'(dones[nd].e), 64'd0);
    check("t3_done1_vaddr", 64'(dones[nd + 1].va), 64'h4000);
    check("t3_done1_end", 64'(dones[nd + 1].e), 64'd1);

    // flush after two of four beats with stale descriptors queued behind it
    nb = beats.size(); nd = dones.size(); np = pops;
    dq.push_back('{v: 48'h5000, s: 28'd256});
    bq.push_back('{d: mk(30), l: 1'b0});
    bq.push_back('{d: mk(31), l: 1'b0});
    wait_count("t4_two_beats", 0, nb + 2);
    flush_next = 1'b1;
    tick();
    dq.push_back('{v: 48'h6000, s: 28'd256});
    dq.push_back('{v: 48'h7000, s: 28'd256});
    dq.push_back('{v: 48'h7800, s: 28'd256});
    bq.push_back('{d: mk(40), l: 1'b0});
    wait_count("t4_drained", 2, np + 4);
    tick();
    tick();
    check("t4_done_cnt", 64'(dones.size()), 64'(nd + 1));
    check("t4_done_vaddr", 64'(dones[nd].va), 64'h5000);
    check("t4_done_bytes", 64'(dones[nd].b), 64'd128);
    check("t4_done_end", 64'(dones[nd].e), 64'd0);
    check("t4_no_beats", 64'(beats.size()), 64'(nb + 2));
    check("t4_idle_ready", 64'(buf_ready), 64'd1);
    dq.push_back('{v: 48'h9000, s: 28'd64});
    wait_count("t4_post_done", 1, nd + 2);
    check("t4_post_vaddr", 64'(beats[nb + 2].va), 64'h9000);
    check("t4_post_last", 64'(beats[nb + 2].bl), 64'd1);
    check_data("t4_post_data", beats[nb + 2].d, mk(40));
    check("t4_post_bytes", 64'(dones[nd + 1].b), 64'd64);

    // flush on the buffer-filling beat while completion is back-pressured
    nb = beats.size(); nd = dones.size(); np = pops;
    dq.push_back('{v: 48'hA000, s: 28'd128});
    bq.push_back('{d: mk(50), l: 1'b0});
    wait_count("t5_first_beat", 0, nb + 1);
    bq.push_back('{d: mk(51), l: 1'b0});
    flush_next = 1'b1;
    done_ready_cfg = 1'b0;
    tick();
    check("t5_fill_beat", 64'(beats.size()), 64'(nb + 2));
    check("t5_fill_last", 64'(beats[nb + 1].bl), 64'd1);
    dq.push_back('{v: 48'hB000, s: 28'd64});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", 64'(done_valid), 64'd1);
      check("t5_hold_vaddr", 64'(done_vaddr), 64'hA000);
      check("t5_hold_bytes", 64'(done_bytes), 64'd128);
      check("t5_hold_end", 64'(done_stream_end), 64'd0);
      check("t5_hold_buf_ready", 64'(buf_ready), 64'd0);
    end
    done_ready_cfg = 1'b1;
    wait_count("t5_done", 1, nd + 1);
    wait_count("t5_stale_pop", 2, np + 2);
    tick();
    tick();
    check("t5_no_new_beats", 64'(beats.size()), 64'(nb + 2));
    check("t5_no_new_done", 64'(dones.size()), 64'(nd + 1));
    check("t5_idle_ready", 64'(buf_ready), 64'd1);

    // reset in the middle of a buffer with out_ready toggling
    nb = beats.size(); nd = dones.size();
    dq.push_back('{v: 48'hD000, s: 28'd256});
    for (int i = 0; i < 4; i++) bq.push_back('{d: mk(60 + i), l: 1'b0});
    toggle_ready = 1'b1;
    wait_count("t6_some_beat", 0, nb + 1);
    tick();
    check("t6_pre_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_buf_ready", 64'(buf_ready), 64'd0);
    check("t6_rst_done_valid", 64'(done_valid), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_wait_out_valid", 64'(out_valid), 64'd0);
      check("t6_wait_in_ready", 64'(in_ready), 64'd0);
    end
    nb = beats.size();
    dq.push_back('{v: 48'hE000, s: 28'd64});
    wait_count("t6_new_done", 1, nd + 1);
    check("t6_new_vaddr", 64'(beats[nb].va), 64'hE000);
    check("t6_new_last", 64'(beats[nb].bl), 64'd1);
    check("t6_new_bytes", 64'(dones[nd].b), 64'd64);
    toggle_ready = 1'b0;
    bq.delete();
    tick();

    check("done_out_overlap", 64'(overlap), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_buffer_writer.md
Name: mem_buffer_writer

Overview:
- Consumer end of the per-stream memory-buffer configuration interface.
- Pops host-enqueued buffer descriptors (vaddr, size) and stamps a virtual address on each beat of an incoming data stream.
- Closes a buffer when it is full or the stream ends, then reports a completion record.
- Honours the flush pulse: the current buffer is closed and all queued stale descriptors are discarded.
- One instance per output stream, sitting between the configuration block and the memory write path.

Parameters:
- VADDR_BITS, 48, virtual address width.
- SIZE_BITS, 28, buffer size width (bytes).
- DATA_BITS, 512, data beat width.
- BEAT_BYTES, DATA_BITS/8, bytes per beat. Must be a power of two.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- buf_valid, in, 1, descriptor available.
- buf_ready, out, 1, descriptor accepted.
- buf_vaddr, in, VADDR_BITS, buffer base address, BEAT_BYTES-aligned.
- buf_size, in, SIZE_BITS, buffer size in bytes.
- flush_buffers, in, 1, single-cycle flush pulse.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted.
- in_data, in, DATA_BITS, input beat.
- in_last, in, 1, last beat of stream.
- out_valid, out, 1, addressed beat valid.
- out_ready, in, 1, downstream accepts.
- out_data, out, DATA_BITS, beat.
- out_vaddr, out, VADDR_BITS, beat address.
- out_buf_last, out, 1, last beat written into the current buffer.
- done_valid, out, 1, completion record valid.
- done_ready, in, 1, completion consumed.
- done_vaddr, out, VADDR_BITS, closed buffer base.
- done_bytes, out, SIZE_BITS, bytes written.
- done_stream_end, out, 1, buffer closed by in_last.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; all counters, flush_pending and registered outputs clear.
  - buf_ready, in_ready, out_valid and done_valid are 0 while in reset.
- Usable beats per buffer = buf_size >> log2(BEAT_BYTES). Remainder bytes are ignored.
- States: IDLE, ACTIVE, DONE, DRAIN.
- IDLE:
  - buf_ready = !flush_pending.
  - On buf handshake: latch base, latch beats_total, clear beat_cnt.
  - If beats_total == 0, the descriptor is dropped with no completion and the state stays IDLE. Otherwise go to ACTIVE.
  - If flush_pending, go to DRAIN.
- ACTIVE:
  - Combinational pass-through: out_valid = in_valid, in_ready = out_ready, out_data = in_data.
  - out_vaddr = base + beat_cnt*BEAT_BYTES.
  - out_buf_last = (beat_cnt == beats_total-1) | in_last.
  - On beat handshake: beat_cnt++.
  - If out_buf_last was set on the handshake, go to DONE with done_bytes = (beat_cnt+1)*BEAT_BYTES and done_stream_end = in_last.
- Flush while ACTIVE:
  - flush_buffers is observed directly or via flush_pending.
  - in_ready and out_valid are forced to 0 from the cycle after the flush is seen.
  - A handshake in the same cycle as the pulse still completes and counts.
  - If the count after that cycle is > 0, go to DONE (done_stream_end = 0). If it is 0, go to DRAIN with no completion.
- DONE:
  - done_valid = 1 with fields held stable.
  - On done_ready: go to DRAIN if flush_pending, else IDLE.
  - in_ready = 0 and buf_ready = 0 throughout.
- DRAIN:
  - buf_ready = 1; every offered descriptor is discarded.
  - When buf_valid is 0, clear flush_pending and go to IDLE.
- flush_pending:
  - Set by flush_buffers in any state.
  - Cleared only on leaving DRAIN.
  - A pulse that arrives during DRAIN keeps it set; exit still happens once buf_valid is 0.
- Same-cycle buffer fill and flush: DONE with the full size, then DRAIN.
- Address arithmetic is modulo 2^VADDR_BITS; there is no overflow check.
- Latency:
  - Beat path: 0 cycles.
  - Descriptor to first accepted beat: 1 cycle.
  - Buffer close to done_valid: 1 cycle.
- done_valid is never asserted in the same cycle as out_valid.

Test Plan:
- Buffer (0x1000, 256) with BEAT_BYTES 64 and 4 beats input → out_vaddr 0x1000, 0x1040, 0x1080, 0x10C0; out_buf_last on beat 4; done(0x1000, 256, end=0).
- Two buffers (0x1000, 128) and (0x8000, 128), then 3 beats with in_last on beat 3 → beats at 0x1000, 0x1040, 0x8000; done(0x1000, 128, 0) and done(0x8000, 64, 1).
- Buffer size 100 → 1 usable beat, done_bytes 64. Buffer size 32 → dropped, no done, next descriptor taken.
- Flush after 2 of 4 beats with 3 descriptors queued → done(base, 128, 0); all 3 descriptors popped with no output; state returns to IDLE.
- Flush pulse in the same cycle as the buffer-filling beat, with done_ready held low 5 cycles → done holds stable with full size; drain begins after the handshake.
- Assert rst_n mid-ACTIVE with out_ready toggling → all valids drop immediately; after release the first beat waits for a new descriptor.
